score_time_display_ctrl: RTL and testbench
==========================================

# score_time_display_ctrl

- Drives the 10x10 digit-glyph ROM (`numbers`) for the score and elapsed-time readouts on the VGA frame.
- Once per frame, at frame start, it snapshots the binary score and time and converts each to three BCD digits with a serial double-dabble sequencer.
- During active video it maps each pixel coordinate to a glyph select and a bit index, pipelined to match the ROM's one-cycle registered read.
- It sits between the game logic / VGA timing generator and `numbers`; its `digit_en` output, aligned with `number_pixel`, gates the green overlay in the VGA colour mux.

## Interface
Parameters:
- `SCORE_X`, 8: left pixel column of the score field.
- `SCORE_Y`, 4: top pixel row of the score field.
- `TIME_X`, 600: left pixel column of the time field.
- `TIME_Y`, 4: top pixel row of the time field.
- `DIGIT_PITCH`, 12: horizontal distance in pixels between digit cell origins; must be ≥ 10.

Ports:
- `clock_25`, in, 1: 25 MHz pixel clock.
- `reset`, in, 1: synchronous, active-high.
- `score`, in, 10: binary score; sampled only on `frame_start`.
- `time_sec`, in, 10: binary elapsed seconds; sampled only on `frame_start`.
- `frame_start`, in, 1: single-cycle pulse at the start of vertical blank.
- `h_count`, in, 10: current pixel column.
- `v_count`, in, 10: current pixel row.
- `selected_number`, out, 4: glyph select to the ROM.
- `number_count`, out, 8: glyph bit index to the ROM.
- `digit_en`, out, 1: the current `number_pixel` belongs to a visible digit cell.
- `bcd_busy`, out, 1: the conversion sequencer is active.

## Operation
Clamping:
- Inputs above 999 are clamped to 999 at snapshot.

Conversion FSM:
- States: IDLE → LOAD → CONV_SCORE → CONV_TIME → COMMIT → IDLE.
- IDLE: wait for `frame_start` = 1.
- LOAD (1 cycle): capture the clamped `score` and `time_sec`, clear the 12-bit BCD accumulator, set shift count = 0.
- CONV_SCORE (10 cycles): each cycle, add 3 to every BCD nibble ≥ 5, then shift the {BCD, bin} register left by 1. Results go to the pending score digits.
- CONV_TIME (10 cycles): the same datapath, reloaded with the time value.
- COMMIT (1 cycle): copy the pending digits to the display digit registers atomically, so no half-updated value is ever displayed.
- `frame_start` seen outside IDLE is ignored; it is not queued.
- A new snapshot is taken at the next `frame_start` in IDLE.

Leading-zero suppression:
- Applied at COMMIT.
- A hundreds digit of 0 becomes glyph 10 (blank).
- A tens digit of 0 becomes blank when the hundreds digit is also 0.
- The units digit is always shown.

Pixel mapping:
- Field f ∈ {score, time}; digit d ∈ 0..2, where d = 0 is the hundreds digit.
- The cell for (f, d) is columns X_f + d·DIGIT_PITCH … +9, rows Y_f … +9.
- Inside a cell: col = h − cell_x, row = v − Y_f, `number_count` = row·10 + col (row-major; 0 = top-left = ROM MSB), `selected_number` = display digit.
- Outside all cells: `selected_number` = 10, `digit_en` = 0.
- The gaps between cells are outside.

## Timing
Reset values:
- `selected_number` = 10, `number_count` = 0, `digit_en` = 0, `bcd_busy` = 0.
- All display digits = 0, then suppressed, so each field shows blank, blank, 0.
- FSM returns to IDLE.
- Reset in any state aborts the conversion; pending digits are discarded.

Conversion timing:
- `frame_start` high at edge k: `bcd_busy` = 1 for edges k+1 … k+22 (LOAD 1 + 10 + 10 + COMMIT 1).
- New digits take effect on the pixel pipeline from the cycle after the COMMIT edge.
- Conversion finishes inside vertical blank.

Pixel pipeline:
- For (h, v) presented in cycle t, `selected_number` is registered at t+1.
- The ROM registers the glyph at t+2.
- `number_count` and `digit_en` are delayed by two registers, so both are valid at t+2, aligned with `number_pixel`.
- Fixed latency is 2 cycles; the VGA controller compensates.
- The display digit registers change only at COMMIT, so there is no glyph tearing within a frame.

## Structure
Shared package `display_pkg`:
- Constants `GLYPH_W = 10`, `GLYPH_BITS = 100`, `BLANK_GLYPH = 4'd10`, `MAX_VAL = 999`.
- The FSM state encoding.

Sub-module `bin2bcd_serial`:
- The 10-bit → 3-digit shift/add-3 datapath, with `start`/`done` control.
- Instantiated once and shared sequentially between score and time.

Top level:
- The FSM, the COMMIT logic, the cell decoder and the 2-stage alignment registers.

## Test plan
- Reset, then idle 5 cycles: `selected_number` = 10, `digit_en` = 0, `bcd_busy` = 0; score field renders blank, blank, 0.
- `score` = 457, `time_sec` = 38, `frame_start` pulse: `bcd_busy` high exactly 22 cycles; afterwards the score digits are 4, 5, 7 and the time digits are blank, 3, 8.
- `score` = 1023: clamped, displayed digits 9, 9, 9.
- Second `frame_start` 5 cycles into a conversion: ignored; `busy` still drops after 22 cycles from the first pulse; values are from the first snapshot.
- With score = 457, present h = SCORE_X+DIGIT_PITCH+3, v = SCORE_Y+2 at cycle t: `selected_number` = 5 at t+1; `number_count` = 23 and `digit_en` = 1 at t+2. Present h = SCORE_X+10 (gap): `digit_en` = 0.
- Assert `reset` at cycle 12 of a conversion of score = 457, after previously displaying 120: FSM in IDLE, display shows blank, blank, 0; a later `frame_start` converts normally.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM encoding and helpers for the score/time overlay
package display_pkg;

  localparam int GLYPH_W = 10;
  localparam int GLYPH_BITS = 100;
  localparam int CNT_W = $clog2(GLYPH_BITS);
  localparam logic [3:0] BLANK_GLYPH = 4'd10;
  localparam int MAX_VAL = 999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV_SCORE,
    ST_CONV_TIME,
    ST_COMMIT
  } conv_state_e;

  function automatic logic [9:0] clamp_val(input logic [9:0] v);
    return (v > 10'(MAX_VAL)) ? 10'(MAX_VAL) : v;
  endfunction

  // Hundreds blank when zero; tens blank only when hundreds is also zero.
  function automatic logic [11:0] suppress_zeros(input logic [11:0] bcd);
    logic [3:0] h;
    logic [3:0] t;
    h = bcd[11:8];
    t = bcd[7:4];
    if (bcd[11:8] == 4'd0) h = BLANK_GLYPH;
    if (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) t = BLANK_GLYPH;
    return {h, t, bcd[3:0]};
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - serial double-dabble, 10-bit binary to three BCD digits
// start loads the operand and performs the first shift; done rises after the tenth shift.
module bin2bcd_serial
  import display_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [9:0]  bin_i,
  output logic [11:0] bcd_o,
  output logic        done_o
);

  logic [21:0] sr_q;
  logic [3:0]  cnt_q;

  function automatic logic [21:0] dd_step(input logic [21:0] s);
    logic [21:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[10+4*i +: 4] >= 4'd5) r[10+4*i +: 4] = r[10+4*i +: 4] + 4'd3;
    end
    return {r[20:0], 1'b0};
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      sr_q  <= dd_step({12'd0, bin_i});
      cnt_q <= 4'd1;
    end else if (cnt_q != 4'd0 && cnt_q != 4'd10) begin
      sr_q  <= dd_step(sr_q);
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign bcd_o  = sr_q[21:10];
  assign done_o = (cnt_q == 4'd10);

endmodule

// File: rtl/score_time_display_ctrl.sv
// rtl/score_time_display_ctrl.sv - per-frame BCD conversion and pixel-to-glyph mapping
// Drives the digit ROM with a fixed two-cycle pixel latency.
module score_time_display_ctrl
  import display_pkg::*;
#(
  parameter int SCORE_X     = 8,
  parameter int SCORE_Y     = 4,
  parameter int TIME_X      = 600,
  parameter int TIME_Y      = 4,
  parameter int DIGIT_PITCH = 12
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic [9:0] score,
  input  logic [9:0] time_sec,
  input  logic       frame_start,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic [3:0] selected_number,
  output logic [7:0] number_count,
  output logic       digit_en,
  output logic       bcd_busy
);

  conv_state_e state_q;
  logic        busy_q;
  logic [9:0]  score_snap_q;
  logic [9:0]  time_snap_q;
  logic [11:0] pend_score_q;
  logic [11:0] pend_time_q;
  logic [11:0] score_disp_q;
  logic [11:0] time_disp_q;

  logic        conv_start;
  logic [9:0]  conv_bin;
  logic [11:0] conv_bcd;
  logic        conv_done;

  assign conv_start = (state_q == ST_LOAD) || (state_q == ST_CONV_SCORE && conv_done);
  assign conv_bin   = (state_q == ST_LOAD) ? score_snap_q : time_snap_q;

  bin2bcd_serial u_bin2bcd (
    .clk_i   (clock_25),
    .reset_i (reset),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .bcd_o   (conv_bcd),
    .done_o  (conv_done)
  );

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      score_snap_q <= '0;
      time_snap_q  <= '0;
      pend_score_q <= '0;
      pend_time_q  <= '0;
      score_disp_q <= {BLANK_GLYPH, BLANK_GLYPH, 4'd0};
      time_disp_q  <= {BLANK_GLYPH, BLANK_GLYPH, 4'd0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            score_snap_q <= clamp_val(score);
            time_snap_q  <= clamp_val(time_sec);
            busy_q       <= 1'b1;
            state_q      <= ST_LOAD;
          end
        end
        ST_LOAD: state_q <= ST_CONV_SCORE;
        ST_CONV_SCORE: begin
          if (conv_done) begin
            pend_score_q <= conv_bcd;
            state_q      <= ST_CONV_TIME;
          end
        end
        ST_CONV_TIME: begin
          if (conv_done) begin
            pend_time_q <= conv_bcd;
            state_q     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          score_disp_q <= suppress_zeros(pend_score_q);
          time_disp_q  <= suppress_zeros(pend_time_q);
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  logic [3:0]       sel_d;
  logic [CNT_W-1:0] cnt_d;
  logic             en_d;
  logic [10:0]      s_rel_h, s_rel_v, t_rel_h, t_rel_v, cell_h;

  // Unsigned wrap makes columns/rows left of or above a field fail the < GLYPH_W test.
  always_comb begin
    sel_d   = BLANK_GLYPH;
    cnt_d   = '0;
    en_d    = 1'b0;
    cell_h  = '0;
    s_rel_h = {1'b0, h_count} - 11'(SCORE_X);
    s_rel_v = {1'b0, v_count} - 11'(SCORE_Y);
    t_rel_h = {1'b0, h_count} - 11'(TIME_X);
    t_rel_v = {1'b0, v_count} - 11'(TIME_Y);
    for (int d = 0; d < 3; d++) begin
      cell_h = s_rel_h - 11'(d * DIGIT_PITCH);
      if (cell_h < 11'(GLYPH_W) && s_rel_v < 11'(GLYPH_W)) begin
        sel_d = score_disp_q[11-4*d -: 4];
        cnt_d = CNT_W'(int'(s_rel_v[3:0]) * GLYPH_W + int'(cell_h[3:0]));
        en_d  = (score_disp_q[11-4*d -: 4] != BLANK_GLYPH);
      end
      cell_h = t_rel_h - 11'(d * DIGIT_PITCH);
      if (cell_h < 11'(GLYPH_W) && t_rel_v < 11'(GLYPH_W)) begin
        sel_d = time_disp_q[11-4*d -: 4];
        cnt_d = CNT_W'(int'(t_rel_v[3:0]) * GLYPH_W + int'(cell_h[3:0]));
        en_d  = (time_disp_q[11-4*d -: 4] != BLANK_GLYPH);
      end
    end
  end

  logic [3:0]       sel_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             en1_q;
  logic [7:0]       cnt2_q;
  logic             en2_q;

  // Select leaves at t+1 for the ROM; count/enable wait one more stage to meet its output.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      sel_q  <= BLANK_GLYPH;
      cnt1_q <= '0;
      en1_q  <= 1'b0;
      cnt2_q <= '0;
      en2_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      cnt1_q <= cnt_d;
      en1_q  <= en_d;
      cnt2_q <= 8'(cnt1_q);
      en2_q  <= en1_q;
    end
  end

  assign selected_number = sel_q;
  assign number_count    = cnt2_q;
  assign digit_en        = en2_q;
  assign bcd_busy        = busy_q;

endmodule

// File: tb/tb_score_time_display_ctrl.sv
// tb/tb_score_time_display_ctrl.sv - scoreboard bench for score_time_display_ctrl
module tb_score_time_display_ctrl;

  typedef struct packed { logic [7:0] cnt; logic en; } pix_t;
  typedef struct packed { logic [3:0] sel; logic en; logic busy; } stat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] score, time_sec, h_count, v_count;
  logic       frame_start;
  logic [3:0] selected_number;
  logic [7:0] number_count;
  logic       digit_en, bcd_busy;

  logic probe = 1'b0, chk_req = 1'b0, done_flag = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0;

  logic [3:0] sel_exp_q[$];
  pix_t       pix_exp_q[$];
  stat_t      stat_exp_q[$];
  int         busy_len_q[$];

  int tests = 0;
  int fails = 0;
  int busy_run = 0;

  always #20 clk = ~clk;

  score_time_display_ctrl dut (
    .clock_25        (clk),
    .reset           (reset),
    .score           (score),
    .time_sec        (time_sec),
    .frame_start     (frame_start),
    .h_count         (h_count),
    .v_count         (v_count),
    .selected_number (selected_number),
    .number_count    (number_count),
    .digit_en        (digit_en),
    .bcd_busy        (bcd_busy)
  );

  always @(posedge clk) begin
    s1 <= probe;
    s2 <= s1;
  end

  task automatic cmp(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every comparison happens here, popping expectations pushed by the stimulus.
  always @(negedge clk) begin
    if (s1) begin
      if (sel_exp_q.size() == 0) cmp("sel_queue_nonempty", 0, 1);
      else cmp("selected_number", selected_number, sel_exp_q.pop_front());
    end
    if (s2) begin
      if (pix_exp_q.size() == 0) cmp("pix_queue_nonempty", 0, 1);
      else begin
        pix_t p;
        p = pix_exp_q.pop_front();
        cmp("digit_en", digit_en, p.en);
        if (p.en) cmp("number_count", number_count, p.cnt);
      end
    end
    if (chk_req) begin
      if (stat_exp_q.size() == 0) cmp("stat_queue_nonempty", 0, 1);
      else begin
        stat_t st;
        st = stat_exp_q.pop_front();
        cmp("idle_selected_number", selected_number, st.sel);
        cmp("idle_digit_en", digit_en, st.en);
        cmp("idle_bcd_busy", bcd_busy, st.busy);
      end
    end
    if (bcd_busy === 1'b1) begin
      busy_run++;
      if (busy_run == 50) cmp("busy_bounded", busy_run, 22);
    end else begin
      if (busy_run > 0) begin
        if (busy_len_q.size() == 0) cmp("busy_queue_nonempty", 0, 1);
        else cmp("busy_length", busy_run, busy_len_q.pop_front());
      end
      busy_run = 0;
    end
    if (done_flag) begin
      cmp("leftover_expectations",
          sel_exp_q.size() + pix_exp_q.size() + stat_exp_q.size() + busy_len_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic probe_px(input int h, input int v, input logic [3:0] es,
                          input logic [7:0] ec, input logic ee);
    pix_t p;
    h_count = h[9:0];
    v_count = v[9:0];
    probe = 1'b1;
    p.cnt = ec;
    p.en  = ee;
    sel_exp_q.push_back(es);
    pix_exp_q.push_back(p);
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  task automatic settle();
    h_count = 10'd700;
    v_count = 10'd400;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic status(input logic [3:0] es, input logic ee, input logic eb);
    stat_t st;
    st.sel = es; st.en = ee; st.busy = eb;
    stat_exp_q.push_back(st);
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic frame(input int s, input int t, input int exp_len);
    score = s[9:0];
    time_sec = t[9:0];
    frame_start = 1'b1;
    busy_len_q.push_back(exp_len);
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bcd_busy) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; score = '0; time_sec = '0;
    h_count = 10'd700; v_count = 10'd400;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    status(4'd10, 1'b0, 1'b0);
    probe_px(8, 4, 4'd10, 8'd0, 1'b0);
    probe_px(25, 13, 4'd10, 8'd95, 1'b0);
    probe_px(41, 4, 4'd0, 8'd9, 1'b1);
    settle();

    frame(457, 38, 22);
    wait_idle();
    status(4'd10, 1'b0, 1'b0);
    probe_px(10, 5, 4'd4, 8'd12, 1'b1);
    probe_px(23, 6, 4'd5, 8'd23, 1'b1);
    probe_px(41, 13, 4'd7, 8'd99, 1'b1);
    probe_px(18, 6, 4'd10, 8'd0, 1'b0);
    probe_px(32, 14, 4'd10, 8'd0, 1'b0);
    probe_px(7, 4, 4'd10, 8'd0, 1'b0);
    probe_px(600, 4, 4'd10, 8'd0, 1'b0);
    probe_px(615, 8, 4'd3, 8'd43, 1'b1);
    probe_px(633, 4, 4'd8, 8'd9, 1'b1);
    probe_px(634, 4, 4'd10, 8'd0, 1'b0);
    settle();

    frame(1023, 5, 22);
    wait_idle();
    probe_px(8, 4, 4'd9, 8'd0, 1'b1);
    probe_px(20, 4, 4'd9, 8'd0, 1'b1);
    probe_px(32, 4, 4'd9, 8'd0, 1'b1);
    probe_px(612, 4, 4'd10, 8'd0, 1'b0);
    probe_px(624, 4, 4'd5, 8'd0, 1'b1);
    settle();

    frame(457, 38, 22);
    repeat (4) @(posedge clk);
    #1 score = 10'd120; time_sec = 10'd0; frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_idle();
    probe_px(8, 4, 4'd4, 8'd0, 1'b1);
    probe_px(20, 4, 4'd5, 8'd0, 1'b1);
    probe_px(32, 4, 4'd7, 8'd0, 1'b1);
    probe_px(615, 8, 4'd3, 8'd43, 1'b1);
    settle();

    frame(105, 1000, 22);
    wait_idle();
    probe_px(8, 4, 4'd1, 8'd0, 1'b1);
    probe_px(20, 4, 4'd0, 8'd0, 1'b1);
    probe_px(32, 4, 4'd5, 8'd0, 1'b1);
    probe_px(600, 4, 4'd9, 8'd0, 1'b1);
    settle();

    frame(120, 40, 22);
    wait_idle();
    probe_px(8, 4, 4'd1, 8'd0, 1'b1);
    probe_px(20, 4, 4'd2, 8'd0, 1'b1);
    probe_px(32, 4, 4'd0, 8'd0, 1'b1);
    probe_px(600, 4, 4'd10, 8'd0, 1'b0);
    probe_px(612, 4, 4'd4, 8'd0, 1'b1);
    settle();

    frame(457, 38, 12);
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    status(4'd10, 1'b0, 1'b0);
    probe_px(8, 4, 4'd10, 8'd0, 1'b0);
    probe_px(20, 4, 4'd10, 8'd0, 1'b0);
    probe_px(32, 4, 4'd0, 8'd0, 1'b1);
    probe_px(624, 4, 4'd0, 8'd0, 1'b1);
    settle();

    frame(457, 38, 22);
    wait_idle();
    probe_px(8, 4, 4'd4, 8'd0, 1'b1);
    probe_px(23, 6, 4'd5, 8'd23, 1'b1);
    probe_px(32, 4, 4'd7, 8'd0, 1'b1);
    probe_px(615, 8, 4'd3, 8'd43, 1'b1);
    settle();

    done_flag = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_finish got=0 exp=1");
    $fatal(1, "monitor did not finish");
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
